// File: rtl/hit_judge.sv
// hit_judge: per-lane note hit/miss judging for a three-lane rhythm game.
//
// Each of key[2:0] (active-low pushbutton) is synchronised, debounced and
// turned into a one-cycle press pulse on the debounced high-to-low edge.
// Each lane then tracks where its note is relative to the judging window
// and scores one hit or one miss per note pass.
//
// Ports
//   clk_50     in   1  sole clock
//   rst        in   1  asynchronous reset, active low
//   key        in   4  raw pushbuttons, active low; key[3] is unused
//   en_play    in   1  play enable; when low, lanes idle and score/combo hold
//   y1, y2, y3 in  10  current note top y per lane
//   hit        out  3  one-cycle hit pulse per lane
//   miss       out  3  one-cycle miss pulse per lane
//   score_bcd  out 12  hit count as three BCD digits, saturates at 999
//   combo      out  8  consecutive-hit count, saturates at 255
//
// Lane FSM
//   state  | meaning
//   ABOVE  | note has not reached the window yet (or respawned)
//   WINDOW | note is inside the window and not yet judged
//   DONE   | note judged (hit or miss); waits for respawn

module hit_judge #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int WIN_TOP         = 384,
    parameter int WIN_BOT         = 424
) (
    input  logic        clk_50,
    input  logic        rst,
    input  logic [3:0]  key,
    input  logic        en_play,
    input  logic [9:0]  y1,
    input  logic [9:0]  y2,
    input  logic [9:0]  y3,
    output logic [2:0]  hit,
    output logic [2:0]  miss,
    output logic [11:0] score_bcd,
    output logic [7:0]  combo
);

    localparam logic [1:0] ST_ABOVE  = 2'd0;
    localparam logic [1:0] ST_WINDOW = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_TERM = CW'(1);
    localparam logic [9:0]    TOP_Y    = 10'(WIN_TOP);
    localparam logic [9:0]    BOT_Y    = 10'(WIN_BOT);

    logic          key_unused;
    logic [2:0]    sync1, sync2, db_level, db_prev, press;
    logic [CW-1:0] db_cnt [3];

    logic [1:0]    state     [3];
    logic [1:0]    state_nxt [3];
    logic [9:0]    y_cur     [3];
    logic [9:0]    y_prev    [3];
    logic [2:0]    hit_nxt, miss_nxt, bad_nxt;
    logic [1:0]    hit_cnt;
    logic [8:0]    combo_sum;
    logic [7:0]    combo_nxt;

    assign key_unused = key[3];
    assign y_cur[0] = y1;
    assign y_cur[1] = y2;
    assign y_cur[2] = y3;

    // Debounce: a down-counter is loaded on the first sample that disagrees
    // with the accepted level and the level flips when it reaches terminal
    // count; any agreeing sample returns the counter to idle (0).
    always_ff @(posedge clk_50 or negedge rst) begin
        if (!rst) begin
            sync1    <= '1;
            sync2    <= '1;
            db_level <= '1;
            db_prev  <= '1;
            press    <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync1   <= key[2:0];
            sync2   <= sync1;
            db_prev <= db_level;
            press   <= db_prev & ~db_level;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (DEBOUNCE_CYCLES == 1 || db_cnt[i] == CNT_TERM) begin
                    db_level[i] <= sync2[i];
                    db_cnt[i]   <= '0;
                end else if (db_cnt[i] == '0) begin
                    db_cnt[i] <= CNT_LOAD;
                end else begin
                    db_cnt[i] <= db_cnt[i] - 1'b1;
                end
            end
        end
    end

    // A press outside WINDOW is a bad press even in a respawn cycle; a press
    // in WINDOW during respawn is simply dropped along with the note.
    always_comb begin
        hit_nxt  = '0;
        miss_nxt = '0;
        bad_nxt  = '0;
        for (int i = 0; i < 3; i++) begin
            state_nxt[i] = state[i];
            if (!en_play) begin
                state_nxt[i] = ST_ABOVE;
            end else begin
                bad_nxt[i] = press[i] && (state[i] != ST_WINDOW);
                if (y_cur[i] < y_prev[i]) begin
                    state_nxt[i] = ST_ABOVE;
                end else begin
                    case (state[i])
                        ST_ABOVE: begin
                            if (y_cur[i] >= BOT_Y) begin
                                miss_nxt[i]  = 1'b1;
                                state_nxt[i] = ST_DONE;
                            end else if (y_cur[i] >= TOP_Y) begin
                                state_nxt[i] = ST_WINDOW;
                            end
                        end
                        ST_WINDOW: begin
                            if (press[i]) begin
                                hit_nxt[i]   = 1'b1;
                                state_nxt[i] = ST_DONE;
                            end else if (y_cur[i] >= BOT_Y) begin
                                miss_nxt[i]  = 1'b1;
                                state_nxt[i] = ST_DONE;
                            end
                        end
                        ST_DONE: ;
                        default: state_nxt[i] = ST_ABOVE;
                    endcase
                end
            end
        end
    end

    function automatic logic [11:0] bcd_add(input logic [11:0] s, input logic [1:0] n);
        logic [4:0] u, t, h;
        u = {1'b0, s[3:0]} + {3'b000, n};
        t = {1'b0, s[7:4]};
        h = {1'b0, s[11:8]};
        if (u > 5'd9) begin
            u = u - 5'd10;
            t = t + 5'd1;
        end
        if (t > 5'd9) begin
            t = t - 5'd10;
            h = h + 5'd1;
        end
        if (h > 5'd9) return 12'h999;
        return {h[3:0], t[3:0], u[3:0]};
    endfunction

    assign hit_cnt   = 2'(hit_nxt[0]) + 2'(hit_nxt[1]) + 2'(hit_nxt[2]);
    assign combo_sum = {1'b0, combo} + {7'b0, hit_cnt};

    always_comb begin
        combo_nxt = combo_sum[8] ? 8'hFF : combo_sum[7:0];
        if (|miss_nxt || |bad_nxt) combo_nxt = 8'd0;
    end

    always_ff @(posedge clk_50 or negedge rst) begin
        if (!rst) begin
            hit       <= '0;
            miss      <= '0;
            score_bcd <= 12'h000;
            combo     <= 8'd0;
            for (int i = 0; i < 3; i++) begin
                state[i]  <= ST_ABOVE;
                y_prev[i] <= '0;
            end
        end else begin
            hit       <= hit_nxt;
            miss      <= miss_nxt;
            score_bcd <= bcd_add(score_bcd, hit_cnt);
            combo     <= combo_nxt;
            for (int i = 0; i < 3; i++) begin
                state[i]  <= state_nxt[i];
                y_prev[i] <= y_cur[i];
            end
        end
    end

endmodule

// File: tb/tb_hit_judge.sv
// Bench for hit_judge with a short debounce. A behavioural model predicts
// hit/miss/score/combo each cycle from key history and note-pass flags;
// directed scenarios add hand-computed literal expectations.

module tb_hit_judge;

    localparam int N   = 4;
    localparam int TOP = 384;
    localparam int BOT = 424;

    logic        clk_50 = 1'b0;
    logic        rst;
    logic [3:0]  key;
    logic        en_play;
    logic [9:0]  y1, y2, y3;
    logic [2:0]  hit, miss;
    logic [11:0] score_bcd;
    logic [7:0]  combo;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    hit_judge #(
        .DEBOUNCE_CYCLES(N),
        .WIN_TOP(TOP),
        .WIN_BOT(BOT)
    ) dut (
        .clk_50(clk_50),
        .rst(rst),
        .key(key),
        .en_play(en_play),
        .y1(y1),
        .y2(y2),
        .y3(y3),
        .hit(hit),
        .miss(miss),
        .score_bcd(score_bcd),
        .combo(combo)
    );

    always #5 clk_50 = ~clk_50;
    always @(posedge clk_50) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic int to_bcd(input int v);
        return (v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10);
    endfunction

    // ---------------- behavioural model ----------------
    logic [2:0] m_hist[$];   // raw key samples, newest first
    logic [2:0] m_db, m_fell, m_press;
    bit         m_judged [3];
    bit         m_saw    [3];
    int         m_yprev  [3];
    int         m_score, m_combo;
    logic [2:0] m_hit, m_miss;

    always @(posedge clk_50 or negedge rst) begin
        if (!rst) begin
            m_hist.delete();
            for (int j = 0; j <= N; j++) m_hist.push_back(3'b111);
            m_db = 3'b111; m_fell = 3'b000; m_press = 3'b000;
            for (int i = 0; i < 3; i++) begin
                m_judged[i] = 0; m_saw[i] = 0; m_yprev[i] = 0;
            end
            m_score = 0; m_combo = 0; m_hit = 3'b000; m_miss = 3'b000;
        end else begin
            int yv [3];
            int nh;
            bit any_clear;
            bit armed, h, ms;
            logic [2:0] nd;
            yv[0] = y1; yv[1] = y2; yv[2] = y3;
            nh = 0; any_clear = 0;
            m_hit = 3'b000; m_miss = 3'b000;
            for (int i = 0; i < 3; i++) begin
                armed = m_saw[i] && !m_judged[i];
                if (!en_play) begin
                    m_judged[i] = 0; m_saw[i] = 0;
                end else begin
                    if (m_press[i] && !armed) any_clear = 1;
                    if (yv[i] < m_yprev[i]) begin
                        m_judged[i] = 0; m_saw[i] = 0;
                    end else begin
                        h  = m_press[i] && armed;
                        ms = !m_judged[i] && (yv[i] >= BOT) && !h;
                        if (h || ms) m_judged[i] = 1;
                        else if (!m_judged[i] && yv[i] >= TOP && yv[i] < BOT) m_saw[i] = 1;
                        m_hit[i] = h; m_miss[i] = ms;
                        if (h) nh++;
                        if (ms) any_clear = 1;
                    end
                end
                m_yprev[i] = yv[i];
            end
            m_score = (m_score + nh > 999) ? 999 : m_score + nh;
            if (any_clear) m_combo = 0;
            else m_combo = (m_combo + nh > 255) ? 255 : m_combo + nh;
            // debounced level = last N synchronised samples, if they agree
            for (int b = 0; b < 3; b++) begin
                bit same;
                same = 1;
                for (int j = 1; j <= N; j++) if (m_hist[j][b] != m_hist[1][b]) same = 0;
                nd[b] = same ? m_hist[1][b] : m_db[b];
            end
            m_press = m_fell;
            m_fell  = m_db & ~nd;
            m_db    = nd;
            m_hist.push_front(key[2:0]);
            void'(m_hist.pop_back());
        end
    end

    always @(negedge clk_50) begin
        check("hit", int'(hit), int'(m_hit));
        check("miss", int'(miss), int'(m_miss));
        check("score", int'(score_bcd), to_bcd(m_score));
        check("combo", int'(combo), m_combo);
    end

    // ---------------- directed stimulus ----------------
    logic [2:0]  hit_acc, miss_acc, first_hit_val;
    int          first_hit;
    logic [11:0] hit_score;
    logic [7:0]  hit_combo;

    task automatic clear_acc();
        hit_acc = 3'b000; miss_acc = 3'b000; first_hit = -1;
        first_hit_val = 3'b000; hit_score = 12'h000; hit_combo = 8'd0;
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk_50); #1;
            hit_acc  = hit_acc | hit;
            miss_acc = miss_acc | miss;
            if (hit != 3'b000 && first_hit < 0) begin
                first_hit = cyc; first_hit_val = hit;
                hit_score = score_bcd; hit_combo = combo;
            end
        end
    endtask

    task automatic set_y(input int lane, input int v);
        case (lane)
            0: y1 = 10'(v);
            1: y2 = 10'(v);
            default: y3 = 10'(v);
        endcase
    endtask

    task automatic single_hit(input int lane);
        set_y(lane, 50);  cycles(1);
        set_y(lane, 400); cycles(2);
        key[lane] = 1'b0; cycles(10);
        key[lane] = 1'b1; cycles(N + 4);
    endtask

    task automatic triple_hit();
        for (int l = 0; l < 3; l++) set_y(l, 50);
        cycles(1);
        for (int l = 0; l < 3; l++) set_y(l, 400);
        cycles(2);
        key[2:0] = 3'b000; cycles(10);
        key[2:0] = 3'b111; cycles(N + 4);
    endtask

    initial begin
        int c0;
        rst = 1'b0; key = 4'hF; en_play = 1'b0; y1 = '0; y2 = '0; y3 = '0;
        clear_acc();
        cycles(3);
        check("rst_hit", int'(hit), 0);
        check("rst_miss", int'(miss), 0);
        check("rst_score", int'(score_bcd), 'h000);
        check("rst_combo", int'(combo), 0);
        rst = 1'b1;
        cycles(2);

        // lane 1 hit, with exact press latency
        en_play = 1'b1;
        y1 = 10'd370; cycles(2);
        y1 = 10'd390; cycles(2);
        clear_acc(); c0 = cyc;
        key[0] = 1'b0; cycles(10);
        key[0] = 1'b1;
        check("t1_latency", first_hit - c0, 2 + N + 1 + 1);
        check("t1_hit", int'(first_hit_val), 'b001);
        check("t1_score", int'(hit_score), 'h001);
        check("t1_combo", int'(hit_combo), 1);
        cycles(N + 4);

        // lane 2 passes the window unpressed
        clear_acc();
        y2 = 10'd390; cycles(2);
        y2 = 10'd430; cycles(1);
        check("t2_miss", int'(miss), 'b010);
        check("t2_combo", int'(combo), 0);
        check("t2_score", int'(score_bcd), 'h001);
        cycles(1);
        check("t2_miss_once", int'(miss), 0);
        check("t2_no_hit", int'(hit_acc), 0);

        // bounce on lane 2 is rejected, stable press is judged
        y2 = 10'd50;  cycles(1);
        y2 = 10'd400; cycles(2);
        clear_acc();
        key[1] = 1'b0; cycles(2);
        key[1] = 1'b1; cycles(12);
        check("t3_glitch", int'(hit_acc), 0);
        key[1] = 1'b0; cycles(10);
        key[1] = 1'b1;
        check("t3_hit", int'(hit_acc), 'b010);
        cycles(N + 4);

        // build combo to 5, then a bad press on lane 1 (DONE)
        for (int r = 0; r < 4; r++) single_hit(2);
        check("t4_combo5", int'(combo), 5);
        clear_acc();
        key[0] = 1'b0; cycles(10);
        key[0] = 1'b1;
        check("t4_bad_combo", int'(combo), 0);
        check("t4_bad_hit", int'(hit_acc), 0);
        check("t4_bad_miss", int'(miss_acc), 0);
        cycles(N + 4);
        y1 = 10'd430; cycles(2);
        check("t4_done_no_miss", int'(miss_acc), 0);
        y1 = 10'd50;  cycles(1);
        y1 = 10'd400; cycles(2);
        clear_acc();
        key[0] = 1'b0; cycles(10);
        key[0] = 1'b1;
        check("t4_respawn_hit", int'(hit_acc), 'b001);
        cycles(N + 4);

        // play disabled: press ignored, score/combo held
        en_play = 1'b0;
        y3 = 10'd50;  cycles(1);
        y3 = 10'd400; cycles(2);
        clear_acc();
        key[2] = 1'b0; cycles(10);
        key[2] = 1'b1; cycles(N + 4);
        check("t6_no_hit", int'(hit_acc), 0);
        check("t6_combo", int'(combo), 1);
        check("t6_score", int'(score_bcd), 'h007);
        en_play = 1'b1;

        // saturation
        for (int it = 0; it < 400 && m_score <= 995; it++) triple_hit();
        for (int it = 0; it < 5 && m_score < 998; it++) single_hit(0);
        check("t5_score998", int'(score_bcd), 'h998);
        check("t5_combo_sat", int'(combo), 255);
        y1 = 10'd50;  cycles(1);
        y1 = 10'd430; cycles(1);
        check("t5_miss", int'(miss), 'b001);
        check("t5_miss_combo", int'(combo), 0);
        cycles(2);
        for (int l = 0; l < 3; l++) set_y(l, 50);
        cycles(1);
        for (int l = 0; l < 3; l++) set_y(l, 400);
        cycles(2);
        clear_acc();
        key[2:0] = 3'b000; cycles(10);
        key[2:0] = 3'b111;
        check("t5_triple", int'(first_hit_val), 'b111);
        check("t5_score999", int'(hit_score), 'h999);
        check("t5_combo3", int'(hit_combo), 3);
        cycles(N + 4);
        triple_hit();
        check("t5_score_hold", int'(score_bcd), 'h999);
        check("t5_combo6", int'(combo), 6);

        // reset mid-debounce while lane 3 is in window
        y3 = 10'd50;  cycles(1);
        y3 = 10'd400; cycles(2);
        key[2] = 1'b0; cycles(3);
        #2 rst = 1'b0;
        #1;
        check("t7_rst_hit", int'(hit), 0);
        check("t7_rst_miss", int'(miss), 0);
        check("t7_rst_score", int'(score_bcd), 'h000);
        check("t7_rst_combo", int'(combo), 0);
        key[2] = 1'b1; cycles(3);
        rst = 1'b1;
        clear_acc();
        cycles(15);
        check("t7_no_hit", int'(hit_acc), 0);
        check("t7_score", int'(score_bcd), 'h000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hit_judge.md
HIT_JUDGE -- requirements
Module: hit_judge

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000; a raw key level must be stable this many clk_50 cycles (10 ms at 50 MHz) before it is accepted.
REQ-002 Parameter WIN_TOP, default 384; the lowest note top y that counts as in-window.
REQ-003 Parameter WIN_BOT, default 424; the first note top y that counts as past the window.
REQ-004 clk_50 input 1: sole clock; all state changes on its rising edge.
REQ-005 rst input 1: reset, asynchronous, active-low.
REQ-006 key input 4: raw DE2 pushbuttons, active-low; key[0] is lane 1, key[1] lane 2, key[2] lane 3, key[3] is ignored.
REQ-007 en_play input 1: play enable from main control.
REQ-008 y1, y2, y3 input 10 each: current top y of the lane 1/2/3 notes, unsigned.
REQ-009 hit output 3: one-cycle pulse per lane on a judged hit.
REQ-010 miss output 3: one-cycle pulse per lane on a judged miss.
REQ-011 score_bcd output 12: three BCD digits of the hit count, [3:0] is units.
REQ-012 combo output 8: current consecutive-hit count.

Function
REQ-013 Each key[2:0] passes through a 2-flop synchronizer, then a per-key debounce counter; the debounced level updates only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
REQ-014 press[i] is a one-cycle pulse on the debounced high-to-low transition of key[i]; there is no press on release and no auto-repeat.
REQ-015 Raw-edge-to-press latency is 2 + DEBOUNCE_CYCLES + 1 cycles, exactly.
REQ-016 Each lane has an FSM with states ABOVE, WINDOW and DONE.
REQ-017 ABOVE -> WINDOW when WIN_TOP <= y < WIN_BOT.
REQ-018 ABOVE -> DONE when y >= WIN_BOT with no press; this also pulses miss[i] (note skipped the window).
REQ-019 WINDOW -> DONE on press[i]; this pulses hit[i].
REQ-020 WINDOW -> DONE when y >= WIN_BOT without a press; this pulses miss[i].
REQ-021 Any state -> ABOVE when y is strictly less than the previous cycle's y (note respawn); no pulse is generated.
REQ-022 press[i] in ABOVE or DONE is a bad press: no hit or miss pulse, and combo clears to 0.
REQ-023 If press[i] and the window-exit condition occur in the same cycle, the hit wins and no miss is generated.
REQ-024 hit and miss for a lane are never asserted together, and each lane pulses at most once per note pass.
REQ-025 Score increments by the number of hit bits set in that cycle (0-3), with BCD carry, and saturates at 999.
REQ-026 Combo increments by the number of hits in the cycle and saturates at 255.
REQ-027 Any miss or bad press in a cycle clears combo to 0, overriding same-cycle hits.
REQ-028 hit/miss pulses, score and combo all update on the clock edge after the triggering condition.
REQ-029 When en_play = 0: all FSMs forced to ABOVE, press pulses discarded, hit/miss held 0, score and combo held.
REQ-030 The previous-y registers update every cycle regardless of en_play.

Reset
REQ-031 rst low immediately clears all of: hit = 0, miss = 0, score_bcd = 12'h000, combo = 0, FSMs = ABOVE, debounce counters = 0.
REQ-032 rst low also sets debounced levels and synchronizers to 1 (released).
REQ-033 Reset assertion mid-debounce or mid-window discards the pending event; no pulse follows deassertion.
REQ-034 Outputs leave reset values only from the first clk_50 edge after rst returns high.

Verification (DEBOUNCE_CYCLES = 4 in bench)
REQ-035 en_play = 1; y1 steps 370 -> 390; key[0] low for 10 cycles -> hit = 3'b001 for one cycle, score_bcd = 12'h001, combo = 1.
REQ-036 y2 steps 390 -> 430 with no press -> miss = 3'b010 for one cycle, combo = 0, score unchanged.
REQ-037 key[1] bounces with a 2-cycle low glitch while y2 = 400 -> no hit; then a stable 10-cycle low -> hit = 3'b010.
REQ-038 Press pulses land in the same cycle on all three lanes, all in window, score = 12'h998 -> score saturates at 12'h999, combo += 3.
REQ-039 Lane 1 in DONE, key[0] pressed with combo = 5 -> combo = 0, no pulse; then y1 drops 430 -> 50 -> lane 1 FSM returns to ABOVE.
REQ-040 rst low while y3 = 400 and a press is mid-debounce -> all outputs 0 immediately, and no hit after release.
